// File: rtl/feature_stream_buf.sv
// Frame-sequenced feature buffer: FIFO input stage, one output register with row/col/last tags.
// First word shows one edge after it is accepted; in_ready drops when the FIFO is full; hold freezes the output stage.

module feature_stream_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == NW'(DEPTH));
    assign empty    = (count == '0);
endmodule

module feature_stream_buf #(
    parameter int DATA_W     = 8,
    parameter int CHANNELS   = 1,
    parameter int DEPTH      = 16,
    parameter int FRAME_ROWS = 28,
    parameter int FRAME_COLS = 28,
    localparam int W  = CHANNELS * DATA_W,
    localparam int RW = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1,
    localparam int CW = (FRAME_COLS > 1) ? $clog2(FRAME_COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    input  logic          hold,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_last,
    output logic          busy,
    output logic          done
);
    localparam int TOTAL = FRAME_ROWS * FRAME_COLS;
    localparam int NW    = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } pos_t;

    state_t        state;
    state_t        state_nxt;
    logic [NW-1:0] in_cnt;
    pos_t          pos;
    logic          fifo_full;
    logic          fifo_empty;
    logic [W-1:0]  fifo_data;
    logic          accept;
    logic          pop;
    logic          handshake;
    logic          frame_start;
    logic          last_in;
    logic          at_row_end;
    logic          at_last_row;

    assign in_ready    = (state == STREAM) && !fifo_full;
    assign accept      = in_valid && in_ready;
    assign handshake   = out_valid && out_ready && !hold;
    assign pop         = !hold && !fifo_empty && (!out_valid || out_ready);
    assign frame_start = start && ((state == IDLE) || (state == DONE));
    assign last_in     = accept && (in_cnt == NW'(TOTAL - 1));
    assign at_row_end  = (pos.col == CW'(FRAME_COLS - 1));
    assign at_last_row = (pos.row == RW'(FRAME_ROWS - 1));

    feature_stream_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)                  state_nxt = STREAM;
            STREAM:  if (last_in)                state_nxt = DRAIN;
            DRAIN:   if (handshake && out_last)  state_nxt = DONE;
            DONE:    if (start)                  state_nxt = STREAM;
            default:                             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_cnt <= '0;
        end else if (frame_start) begin
            in_cnt <= '0;
        end else if (accept) begin
            in_cnt <= in_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= fifo_data;
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    // Tags follow the word held in the output register; the final handshake wraps them to 0,0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos <= '0;
        end else if (frame_start) begin
            pos <= '0;
        end else if (handshake) begin
            if (at_row_end) begin
                pos.col <= '0;
                pos.row <= at_last_row ? '0 : pos.row + 1'b1;
            end else begin
                pos.col <= pos.col + 1'b1;
            end
        end
    end

    assign out_row  = pos.row;
    assign out_col  = pos.col;
    assign out_last = out_valid && at_last_row && at_row_end;
    assign busy     = (state == STREAM) || (state == DRAIN);
    assign done     = (state == DONE);
endmodule

// File: tb/tb_feature_stream_buf.sv
// Bench for feature_stream_buf: 2x3 frames of 3-channel words, scoreboarded output order and tags.
module tb_feature_stream_buf;
    localparam int DATA_W   = 8;
    localparam int CHANNELS = 3;
    localparam int DEPTH    = 4;
    localparam int ROWS     = 2;
    localparam int COLS     = 3;
    localparam int W        = DATA_W * CHANNELS;
    localparam int TOTAL    = ROWS * COLS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         hold;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [0:0]   out_row;
    logic [1:0]   out_col;
    logic         out_last;
    logic         busy;
    logic         done;

    typedef struct packed {
        logic [W-1:0] d;
        logic [1:0]   r;
        logic [1:0]   c;
        logic         l;
    } exp_t;

    exp_t sb[$];
    int   acc_idx;
    int   n_chk;
    int   n_fail;

    feature_stream_buf #(
        .DATA_W     (DATA_W),
        .CHANNELS   (CHANNELS),
        .DEPTH      (DEPTH),
        .FRAME_ROWS (ROWS),
        .FRAME_COLS (COLS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .hold      (hold),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] mcw(input int k);
        return {8'(3 * k), 8'(3 * k - 1), 8'(3 * k - 2)};
    endfunction

    task automatic push_word(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) break;
            tick();
        end
        chk("push_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (done) break;
            tick();
        end
        chk("done_reached", done, 1);
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_row", out_row, 0);
        chk("start_col", out_col, 0);
    endtask

    // Model: expected words and their frame position are queued at every accept.
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t g;
        if (!rst) begin
            sb.delete();
            acc_idx = 0;
        end else begin
            if (in_valid && in_ready) begin
                e.d = in_data;
                e.r = 2'(acc_idx / COLS);
                e.c = 2'(acc_idx % COLS);
                e.l = (acc_idx == TOTAL - 1);
                sb.push_back(e);
                acc_idx = (acc_idx + 1) % TOTAL;
            end
            if (out_valid && out_ready && !hold) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(sb.size()), 1);
                end else begin
                    g = sb.pop_front();
                    chk("sb_data", out_data, g.d);
                    chk("sb_row", out_row, g.r);
                    chk("sb_col", out_col, g.c);
                    chk("sb_last", out_last, g.l);
                end
            end
        end
    end

    initial begin
        int acc;
        logic [W-1:0] snap_d;
        n_chk = 0; n_fail = 0;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        hold = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_tags", {out_row, out_col, out_last}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 0);

        // Basic frame, back-to-back, then a source that keeps pushing 0xAA.
        out_ready = 1'b1;
        start_frame();
        for (int i = 1; i <= TOTAL; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            chk("basic_in_ready", in_ready, 1);
            tick();
            if (i == 1) begin
                chk("basic_latency_early", out_valid, 0);
            end else begin
                chk("basic_out_valid", out_valid, 1);
                chk("basic_consecutive", out_data, W'(i - 1));
            end
        end
        in_data = W'(8'hAA);
        chk("drain_in_ready", in_ready, 0);
        start = 1'b1;
        tick();
        chk("basic_last_data", out_data, W'(6));
        chk("basic_last_flag", out_last, 1);
        chk("basic_not_done_yet", done, 0);
        tick();
        start = 1'b0;
        chk("basic_done", done, 1);
        chk("basic_idle_busy", busy, 0);
        chk("done_no_aa", out_valid, 0);
        tick();
        tick();
        chk("done_in_ready", in_ready, 0);
        chk("done_still_done", done, 1);
        chk("done_no_aa_later", out_valid, 0);
        in_valid = 1'b0;

        // Backpressure: output register plus full FIFO absorb five words.
        start_frame();
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data  = W'(8'h10 + acc);
            if (in_ready) acc++;
            tick();
        end
        chk("bp_accept_count", acc, 5);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_head", out_data, W'(8'h10));
        out_ready = 1'b1;
        tick();
        chk("bp_ready_after_pop", in_ready, 1);
        tick();
        in_valid = 1'b0;
        wait_done();

        // Hold stall with multi-channel words.
        start_frame();
        push_word(mcw(1));
        push_word(mcw(2));
        chk("mc_byte_order", out_data, W'(24'h030201));
        hold   = 1'b1;
        snap_d = out_data;
        for (int k = 3; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = mcw(k);
            chk("hold_in_ready", in_ready, 1);
            tick();
            chk("hold_data", out_data, snap_d);
            chk("hold_valid", out_valid, 1);
            chk("hold_tags", {out_row, out_col}, 0);
        end
        in_valid = 1'b0;
        chk("hold_full", in_ready, 0);
        hold = 1'b0;
        push_word(mcw(6));
        wait_done();

        // Reset in the middle of a frame, then a clean frame.
        start_frame();
        for (int k = 1; k <= 3; k++) push_word(W'(8'h40 + k));
        chk("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_tags", {out_row, out_col, out_last}, 0);
        chk("mid_rst_busy_done", {busy, done}, 0);
        tick();
        rst = 1'b1;
        tick();
        start_frame();
        for (int k = 1; k <= TOTAL; k++) push_word(W'(8'h50 + k));
        wait_done();

        tick();
        chk("sb_drained", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
